// File: rtl/cpu_pkg.sv
// Shared CPU package: commit-lane record and writeback helpers.
package cpu_pkg;

  localparam int WB_LANES_MAX     = 4;
  localparam int WB_XLEN_MAX      = 64;
  localparam int WB_REG_IDX_W_MAX = 8;

  // Fields are sized for the widest supported core; narrower cores zero-extend.
  typedef struct packed {
    logic                        valid;
    logic                        we;
    logic                        wr_pc4;
    logic [WB_REG_IDX_W_MAX-1:0] rd;
    logic [WB_XLEN_MAX-1:0]      pc;
    logic [WB_XLEN_MAX-1:0]      result;
  } wb_lane_t;

  function automatic logic [2:0] wb_popcount(input logic [WB_LANES_MAX-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < WB_LANES_MAX; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/wb_waw_filter.sv
// Write-after-write resolution across commit lanes: the youngest (highest-index)
// qualifying lane keeps its regfile write; older lanes to the same rd are dropped.
module wb_waw_filter #(
  parameter int LANES     = 2,
  parameter int REG_IDX_W = 5
) (
  input  logic [LANES-1:0]           qual,
  input  logic [LANES*REG_IDX_W-1:0] rd,
  output logic [LANES-1:0]           we
);

  always_comb begin
    we = qual;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (qual[j] && (rd[j*REG_IDX_W +: REG_IDX_W] == rd[i*REG_IDX_W +: REG_IDX_W]))
          we[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/writeback_multi.sv
// Multi-lane writeback/commit stage with WAW filtering and retire counter.
// Optional per-lane retirement trace ports are enabled by defining WB_TRACE_EN.
module writeback_multi
  import cpu_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       stall_i,
  output logic                       stall_o,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_we,
  input  logic [LANES-1:0]           in_wr_pc4,
  input  logic [LANES*REG_IDX_W-1:0] in_rd,
  input  logic [LANES*XLEN-1:0]      in_pc,
  input  logic [LANES*XLEN-1:0]      in_result,
  output logic [LANES-1:0]           reg_we,
  output logic [LANES*REG_IDX_W-1:0] reg_idx,
  output logic [LANES*XLEN-1:0]      reg_data,
  output logic [63:0]                retire_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [LANES-1:0]           trace_valid,
  output logic [LANES*XLEN-1:0]      trace_pc,
  output logic [LANES-1:0]           trace_wen,
  output logic [LANES*REG_IDX_W-1:0] trace_wdest,
  output logic [LANES*XLEN-1:0]      trace_wdata
`endif
);

  wb_lane_t                   in_lane [LANES];
  wb_lane_t                   held    [LANES];
  logic [LANES-1:0]           held_valid;
  logic [LANES-1:0]           qual;
  logic [LANES-1:0]           waw_we;
  logic [LANES*REG_IDX_W-1:0] rd_flat;
  logic                       retire;

  assign stall_o = stall_i;
  assign retire  = !stall_i && !flush_i;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_lane[i]        = '0;
      in_lane[i].valid  = in_valid[i];
      in_lane[i].we     = in_we[i];
      in_lane[i].wr_pc4 = in_wr_pc4[i];
      in_lane[i].rd     = WB_REG_IDX_W_MAX'(in_rd[i*REG_IDX_W +: REG_IDX_W]);
      in_lane[i].pc     = WB_XLEN_MAX'(in_pc[i*XLEN +: XLEN]);
      in_lane[i].result = WB_XLEN_MAX'(in_result[i*XLEN +: XLEN]);
    end
  end

  // Input register: stall holds the bundle, flush kills valids even under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) held[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!stall_i) held[i] <= in_lane[i];
        if (flush_i)  held[i].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      held_valid[i] = held[i].valid;
      rd_flat[i*REG_IDX_W +: REG_IDX_W] = held[i].rd[REG_IDX_W-1:0];
      qual[i] = held[i].valid && held[i].we && (held[i].rd[REG_IDX_W-1:0] != '0);
      reg_data[i*XLEN +: XLEN] = held[i].wr_pc4 ? (held[i].pc[XLEN-1:0] + XLEN'(4))
                                                : held[i].result[XLEN-1:0];
    end
  end

  wb_waw_filter #(
    .LANES     (LANES),
    .REG_IDX_W (REG_IDX_W)
  ) u_waw_filter (
    .qual (qual),
    .rd   (rd_flat),
    .we   (waw_we)
  );

  assign reg_we  = waw_we;
  assign reg_idx = rd_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 64'(wb_popcount(WB_LANES_MAX'(held_valid)));
  end

`ifdef WB_TRACE_EN
  logic [LANES*XLEN-1:0] pc_flat;

  always_comb begin
    for (int i = 0; i < LANES; i++) pc_flat[i*XLEN +: XLEN] = held[i].pc[XLEN-1:0];
  end

  // Trace snapshots the bundle retiring on this edge; valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= '0;
      trace_pc    <= '0;
      trace_wen   <= '0;
      trace_wdest <= '0;
      trace_wdata <= '0;
    end else begin
      trace_valid <= retire ? held_valid : '0;
      if (retire) begin
        trace_pc    <= pc_flat;
        trace_wen   <= waw_we;
        trace_wdest <= rd_flat;
        trace_wdata <= reg_data;
      end
    end
  end
`endif

endmodule

// File: doc/writeback_multi.md
WRITEBACK_MULTI -- requirements
Module: writeback_multi

Interface
REQ-001 SHALL have parameter LANES, default 2: number of commit lanes, 1..4.
REQ-002 SHALL have parameter XLEN, default 32: data/PC width.
REQ-003 SHALL have parameter REG_IDX_W, default 5: register index width.
REQ-004 SHALL have port clk  in  1  clock; all flops rise-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  kill held bundle.
REQ-007 SHALL have port stall_i  in  1  downstream stall.
REQ-008 SHALL have port stall_o  out  1  stall to upstream.
REQ-009 SHALL have port in_valid  in  LANES  per-lane instruction valid.
REQ-010 SHALL have port in_we  in  LANES  per-lane writes rd.
REQ-011 SHALL have port in_wr_pc4  in  LANES  write pc+4 instead of result.
REQ-012 SHALL have port in_rd  in  LANES x REG_IDX_W  destination index.
REQ-013 SHALL have port in_pc  in  LANES x XLEN  instruction PC.
REQ-014 SHALL have port in_result  in  LANES x XLEN  execute/memory result.
REQ-015 SHALL have ports reg_we, reg_idx, reg_data  out  LANES, LANES x REG_IDX_W, LANES x XLEN  regfile write ports.
REQ-016 SHALL have port retire_cnt  out  64  retired-instruction count.

Function
REQ-017 SHALL capture all in_* into a per-lane input register on every edge with stall_i low; hold it when stall_i high.
REQ-018 SHALL clear every held lane valid on an edge with flush_i high; flush SHALL override stall.
REQ-019 SHALL drive stall_o = stall_i combinationally.
REQ-020 SHALL drive reg_we[i] = held valid[i] & held we[i] & (held rd[i] != 0), independent of stall (rewrite is idempotent).
REQ-021 SHALL, when lanes i<j both qualify for the same rd, deassert reg_we[i]; the highest-index lane wins (program order).
REQ-022 SHALL drive reg_data[i] = held wr_pc4[i] ? held pc[i]+4 (mod 2^XLEN) : held result[i]; reg_idx[i] = held rd[i].
REQ-023 SHALL add popcount(held valid) to retire_cnt on each edge with stall_i low and flush_i low; wrap at 2^64.
REQ-024 SHALL accept any valid pattern, including non-contiguous (e.g. 2'b10).
REQ-025 SHALL let a bundle held during a flush edge still drive reg_we combinationally before that edge.

Reset
REQ-026 SHALL on rst_n low clear all held valids, retire_cnt to 0, all trace outputs to 0; reg_we SHALL therefore be 0.
REQ-027 SHALL keep reset effective mid-stall; first edge after release with stall_i low captures new inputs.

Configuration
REQ-028 SHALL, with WB_TRACE_EN defined, add outputs trace_valid (LANES), trace_pc, trace_wen, trace_wdest, trace_wdata (per lane), registered one cycle after each retirement edge of REQ-023, trace_wen post-WAW-filter.
REQ-029 SHALL, with WB_TRACE_EN undefined, omit trace ports and flops entirely; all other behaviour identical.

Structure
REQ-030 SHALL place wb_lane_t (valid, we, wr_pc4, rd, pc, result) and WB_LANES_MAX=4 in the shared cpu package.
REQ-031 SHALL implement WAW resolution in sub-module wb_waw_filter (pure combinational, LANES-parametrised).

Verification
REQ-032 SHALL test: LANES=2, lane0 rd=3 result=0x11, lane1 rd=3 result=0x22, both we -> only reg_we[1], regfile r3=0x22.
REQ-033 SHALL test: lane0 rd=0 we=1 -> reg_we[0]=0; retire_cnt still +1.
REQ-034 SHALL test: lane1 wr_pc4 pc=0xFFFFFFFC -> reg_data[1]=0x00000000.
REQ-035 SHALL test: stall_i high 3 cycles with bundle valid=2'b11 -> retire_cnt increases by exactly 2 total, held data unchanged.
REQ-036 SHALL test: flush_i and stall_i high together -> next cycle reg_we=0, retire_cnt unchanged.
REQ-037 SHALL test: WB_TRACE_EN, bundle pc=0x1c000000/0x1c000004 retires -> trace_valid=2'b11 next cycle with matching pc/wdata.
